// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the async-SRAM controller: FSM state codes,
// default timing constants and a small sizing helper.
package sram_ctrl_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_TURN     = 3'd5;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;
  localparam int DEF_TURN    = 1;

  // Largest of three timing values; sizes the shared wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_dq_pad.sv
// Bidirectional SRAM data pad: registered output data and drive enable,
// plus the read-capture register that feeds rdata.
module sram_dq_pad #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,   // latch write data (write accept)
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              drv_d_i,  // next-cycle drive enable
  input  logic              cap_i,    // sample dq on this edge
  output logic [DATA_W-1:0] rdata_o,
  inout  wire  [DATA_W-1:0] dq_io
);

  logic [DATA_W-1:0] dout_q, rdata_q;
  logic              drv_q;

  assign dq_io   = drv_q ? dout_q : {DATA_W{1'bz}};
  assign rdata_o = rdata_q;

  // Output data/enable registers and read capture; reset releases the bus at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q  <= '0;
      drv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (load_i) dout_q <= wdata_i;
      drv_q <= drv_d_i;
      if (cap_i) rdata_q <= dq_io;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Async-SRAM controller top: req/ready front end, one access in flight,
// registered strobes, programmable read/write waits and write turnaround.
// Optional SRAM_CTRL_STATS_EN adds rd_count_o / wr_count_o completion counters.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int TURN    = DEF_TURN,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              wdone_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_cs_n_o,
  output logic              sram_we_n_o,
  output logic              sram_oe_n_o,
  output logic [BE_W-1:0]   sram_be_n_o,
`ifdef SRAM_CTRL_STATS_EN
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o,
`endif
  inout  wire  [DATA_W-1:0] sram_dq_io
);

  localparam int CNT_W = $clog2(max3(RD_WAIT, WR_WAIT, TURN) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, cap;
  logic              cs_n_q, we_n_q, oe_n_q, rvalid_q, wdone_q;
  logic              cs_n_d, we_n_d, oe_n_d, rvalid_d, wdone_d, drv_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign ready_o = (state_q == S_IDLE);
  assign accept  = req_i && ready_o;
  // Last read-wait cycle: sample the bus and flag rvalid for the next cycle.
  assign cap     = (state_q == S_RD) && (cnt_q == '0);

  // State and wait-counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; one down-counter times every multi-cycle phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (wr_i) state_d = S_WR_SETUP;
        else begin
          state_d = S_RD;
          cnt_d   = RD_LOAD;
        end
      end
      S_RD: if (cnt_q == '0) state_d = S_IDLE;
            else cnt_d = cnt_q - CNT_ONE;
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: if (cnt_q == '0) state_d = S_WR_HOLD;
                  else cnt_d = cnt_q - CNT_ONE;
      S_WR_HOLD: if (TURN == 0) state_d = S_IDLE;
                 else begin
                   state_d = S_TURN;
                   cnt_d   = TURN_LOAD;
                 end
      S_TURN: if (cnt_q == '0) state_d = S_IDLE;
              else cnt_d = cnt_q - CNT_ONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state so every
  // strobe leaves a flop; byte lanes are taken at accept and held after.
  always_comb begin
    cs_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    be_n_d   = '1;
    drv_d    = 1'b0;
    addr_d   = accept ? addr_i : addr_q;
    rvalid_d = cap;
    wdone_d  = (state_q == S_WR_HOLD);
    case (state_d)
      S_RD: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      S_WR_SETUP: begin
        cs_n_d = 1'b0;
        be_n_d = ~be_i;
        drv_d  = 1'b1;
      end
      S_WR_PULSE: begin
        cs_n_d = 1'b0;
        we_n_d = 1'b0;
        be_n_d = be_n_q;
        drv_d  = 1'b1;
      end
      S_WR_HOLD: begin
        cs_n_d = 1'b0;
        be_n_d = be_n_q;
        drv_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered SRAM pins and completion pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      be_n_q   <= '1;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      cs_n_q   <= cs_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      be_n_q   <= be_n_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
    end
  end

  assign sram_cs_n_o = cs_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_be_n_o = be_n_q;
  assign sram_addr_o = addr_q;
  assign rvalid_o    = rvalid_q;
  assign wdone_o     = wdone_q;

  sram_dq_pad #(.DATA_W(DATA_W)) u_pad (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (accept && wr_i),
    .wdata_i (wdata_i),
    .drv_d_i (drv_d),
    .cap_i   (cap),
    .rdata_o (rdata_o),
    .dq_io   (sram_dq_io)
  );

`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Completion counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rvalid_q) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wdone_q)  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`else
  // Statistics disabled: no counters, access timing unchanged.
`endif

endmodule
